alu_wide_seq: RTL
=================

# alu_wide_seq

Multi-cycle sequencer that performs 16-bit (SLICES×WIDTH) add, subtract, AND and XOR operations on the existing narrow `alu`. It processes one WIDTH-bit slice per cycle, least-significant slice first, and chains the carry between slices. It accepts one command at a time through a start/ready handshake, holds registered results and flags, and pulses `done` on completion. The block sits between a command source (bench or future control unit) and a single internal `alu` instance.

## Interface
- `WIDTH`, 4: slice width; must equal the `alu` data width.
- `SLICES`, 4: number of slices; operand width is N = WIDTH×SLICES.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `start`  in  1  command request; sampled only when `ready`=1.
- `cmd`  in  2  operation code, from `alu_pkg`: CMD_ADD, CMD_SUB, CMD_AND, CMD_XOR.
- `a`  in  N  first operand; latched when `start` is accepted.
- `b`  in  N  second operand; latched when `start` is accepted.
- `ready`  out  1  high in IDLE only.
- `done`  out  1  one-cycle pulse when the result is valid.
- `result`  out  N  result register; holds until the next accepted start.
- `carry`  out  1  final carry; for SUB, 1 means no borrow.
- `zero`  out  1  `result`==0 across all N bits.
- `overflow`  out  1  signed overflow of the N-bit ADD/SUB.

## Operation
- FSM states and transitions:
  - IDLE → RUN on `start`&`ready`. At that edge: latch `cmd`, `a`, `b`; set slice index = 0; set carry register = (cmd==CMD_SUB).
  - RUN: each cycle presents slice [idx] of the latched operands to the `alu`:
    - `in_x` = a slice.
    - `in_y` = b slice, inverted when the command is SUB.
    - `in_c` = carry register for ADD/SUB, 0 for logic operations.
    - `op` = ALU_ADD for ADD/SUB, ALU_AND for AND, ALU_XOR for XOR.
  - Each RUN edge:
    - Write `alu` `out_s` into `result` slice [idx].
    - Carry register ← `out_c`.
    - idx ← idx+1.
  - On the edge where idx==SLICES-1: also capture `overflow` from the `alu` and go to DONE.
  - DONE → IDLE unconditionally after one cycle.
- `result` is cleared to 0 on accept, then filled slice by slice during RUN. It is stable from DONE onward.
- Flags are valid from DONE onward and hold until the next accept:
  - `carry` = final carry register for ADD/SUB, 0 for AND/XOR.
  - `overflow` = last-slice `alu` overflow for ADD/SUB, 0 for AND/XOR.
  - `zero` is derived from the `result` register.
- Arithmetic is modulo 2^N. The `alu` zero output is unused.
- `start` while `ready`=0 is ignored, with no queueing. Operand changes after accept have no effect.
- Reset mid-operation aborts the command with no partial `done`.

## Timing
- Reset values: `ready`=1, `done`=0, `result`=0, `carry`=0, `zero`=1, `overflow`=0, state IDLE, idx=0.
- Let start be accepted at edge E.
  - Slices are captured at edges E+1 … E+SLICES.
  - `done`=1 during the cycle after edge E+SLICES (latency: SLICES cycles).
  - `ready` returns high after edge E+SLICES+1.
  - Earliest next accept is edge E+SLICES+2.
  - Throughput: one command per SLICES+2 cycles.
- The `alu` path is combinational within one cycle. Its inputs come from registers only, never directly from ports.

## Structure
- Shared package `alu_pkg`:
  - CMD_* encodings (CMD_ADD=0, CMD_SUB=1, CMD_AND=2, CMD_XOR=3).
  - ALU_* op-code constants for the `alu` (ALU_ADD, ALU_AND, ALU_XOR).
  - FSM state enum (IDLE, RUN, DONE).
- One sub-module: the existing `alu`, instantiated once with WIDTH. No other hierarchy.

## Test plan
Expected values assume defaults (N=16).
- ADD 0x00FF+0x0001 → `result`=0x0100, `carry`=0, `overflow`=0, `zero`=0. `done` is high exactly 4 cycles after the accept edge, for 1 cycle.
- ADD 0x7FFF+0x0001 → 0x8000, `overflow`=1, `carry`=0. Then ADD 0xFFFF+0x0001 → 0x0000, `carry`=1, `zero`=1, `overflow`=0.
- SUB 0x1234−0x1234 → 0x0000, `zero`=1, `carry`=1. Then SUB 0x0000−0x0001 → 0xFFFF, `carry`=0, `overflow`=0. Then SUB 0x8000−0x0001 → 0x7FFF, `overflow`=1.
- XOR 0xA5A5^0xFFFF → 0x5A5A. AND 0xF0F0&0x3C3C → 0x3030. Both give `carry`=0, `overflow`=0.
- `start` held high continuously with changing operands → only commands at accept edges execute, spaced 6 cycles apart. Operand changes during RUN do not alter `result`.
- Assert `rst` mid-RUN (after slice 1) → immediately `ready`=1, `result`=0, `done` never pulses. The next ADD 0x0003+0x0004 → 0x0007 correct.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared encodings for the narrow alu and the wide sequencer:
//                command codes, alu op codes and sequencer FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Wide sequencer command codes
    localparam logic [1:0] CMD_ADD = 2'd0;
    localparam logic [1:0] CMD_SUB = 2'd1;
    localparam logic [1:0] CMD_AND = 2'd2;
    localparam logic [1:0] CMD_XOR = 2'd3;

    // Narrow alu operation codes
    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_AND = 2'd1;
    localparam logic [1:0] ALU_XOR = 2'd2;

    // Sequencer FSM states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
//  Module      : alu
//  Description : Narrow combinational ALU. ADD uses the carry input and
//                reports carry-out and signed overflow; AND/XOR report
//                neither.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    input  logic             in_c,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] out_s,
    output logic             out_c,
    output logic             zero,
    output logic             overflow
);

    logic [WIDTH:0] w_sum;

    assign w_sum = {1'b0, in_x} + {1'b0, in_y} + {{WIDTH{1'b0}}, in_c};

    // Operation select; signed overflow when both operands share a sign the sum lacks
    always_comb begin
        out_s    = '0;
        out_c    = 1'b0;
        overflow = 1'b0;
        case (op)
            ALU_ADD: begin
                out_s    = w_sum[WIDTH-1:0];
                out_c    = w_sum[WIDTH];
                overflow = (in_x[WIDTH-1] == in_y[WIDTH-1]) &&
                           (w_sum[WIDTH-1] != in_x[WIDTH-1]);
            end
            ALU_AND: out_s = in_x & in_y;
            ALU_XOR: out_s = in_x ^ in_y;
            default: out_s = '0;
        endcase
    end

    assign zero = ~|out_s;

endmodule : alu
`default_nettype wire

// File: rtl/alu_wide_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_wide_seq
//  Description : Multi-cycle wide ADD/SUB/AND/XOR built on one narrow alu.
//                One slice per cycle, LSB slice first, carry chained through
//                a register. Start/ready handshake, one-cycle done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_wide_seq
    import alu_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int SLICES = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [1:0]                cmd,
    input  logic [WIDTH*SLICES-1:0]   a,
    input  logic [WIDTH*SLICES-1:0]   b,
    output logic                      ready,
    output logic                      done,
    output logic [WIDTH*SLICES-1:0]   result,
    output logic                      carry,
    output logic                      zero,
    output logic                      overflow
);

    localparam int N     = WIDTH * SLICES;
    localparam int IDX_W = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(SLICES - 1);

    logic [1:0]       r_state;
    logic [IDX_W-1:0] r_idx;
    logic [1:0]       r_cmd;
    logic [N-1:0]     r_a;
    logic [N-1:0]     r_b;
    logic             r_cy;
    logic [N-1:0]     r_result;
    logic             r_carry;
    logic             r_ovf;

    int               w_base;
    logic             w_arith;
    logic [WIDTH-1:0] w_x;
    logic [WIDTH-1:0] w_y;
    logic             w_c;
    logic [1:0]       w_op;
    logic [WIDTH-1:0] w_out_s;
    logic             w_out_c;
    logic             w_alu_ovf;
    logic             w_alu_zero_unused;

    // Slice select and command decode; alu inputs come from latched registers only
    always_comb begin
        w_base  = int'(r_idx) * WIDTH;
        w_arith = (r_cmd == CMD_ADD) || (r_cmd == CMD_SUB);
        w_x     = r_a[w_base +: WIDTH];
        w_y     = (r_cmd == CMD_SUB) ? ~r_b[w_base +: WIDTH] : r_b[w_base +: WIDTH];
        w_c     = w_arith ? r_cy : 1'b0;
        case (r_cmd)
            CMD_AND: w_op = ALU_AND;
            CMD_XOR: w_op = ALU_XOR;
            default: w_op = ALU_ADD;
        endcase
    end

    alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .in_x     (w_x),
        .in_y     (w_y),
        .in_c     (w_c),
        .op       (w_op),
        .out_s    (w_out_s),
        .out_c    (w_out_c),
        .zero     (w_alu_zero_unused),
        .overflow (w_alu_ovf)
    );

    // Sequencer: accept in IDLE, one slice per RUN cycle, single DONE cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_idx    <= '0;
            r_cmd    <= CMD_ADD;
            r_a      <= '0;
            r_b      <= '0;
            r_cy     <= 1'b0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_cmd    <= cmd;
                        r_a      <= a;
                        r_b      <= b;
                        r_idx    <= '0;
                        // SUB is a + ~b + 1, so the chain starts with carry set
                        r_cy     <= (cmd == CMD_SUB);
                        r_result <= '0;
                        r_carry  <= 1'b0;
                        r_ovf    <= 1'b0;
                        r_state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_result[w_base +: WIDTH] <= w_out_s;
                    r_cy  <= w_out_c;
                    r_idx <= r_idx + 1'b1;
                    if (r_idx == c_LAST_IDX) begin
                        r_carry <= w_arith ? w_out_c   : 1'b0;
                        r_ovf   <= w_arith ? w_alu_ovf : 1'b0;
                        r_idx   <= '0;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ready    = (r_state == ST_IDLE);
    assign done     = (r_state == ST_DONE);
    assign result   = r_result;
    assign carry    = r_carry;
    assign overflow = r_ovf;
    assign zero     = ~|r_result;

endmodule : alu_wide_seq
`default_nettype wire
